// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: set-associative cache miss sequencer with tree-pLRU replacement,
// write-back eviction, line fill with replay, and saturating hit/miss counters.
module cache_miss_ctrl #(
    parameter int WAYS        = 4,
    parameter int IDX_BITS    = 13,
    parameter int WRITE_ALLOC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pe_read,
    input  logic                     pe_write,
    input  logic [IDX_BITS-1:0]      pe_index,
    output logic                     pe_ready,
    input  logic [WAYS-1:0]          lk_hit,
    input  logic [WAYS-1:0]          lk_val,
    input  logic [WAYS-1:0]          lk_mod,
    output logic                     mm_read,
    output logic                     mm_write,
    input  logic                     mm_busy,
    input  logic                     mm_readdata_valid,
    output logic [WAYS-1:0]          ary_write,
    output logic [WAYS-1:0]          tag_write,
    output logic                     ary_fill,
    output logic                     val_set,
    output logic                     mod_set,
    output logic                     mod_clr,
    output logic [$clog2(WAYS)-1:0]  victim_way,
    output logic                     rd_valid,
    output logic                     req_hit,
    output logic                     req_miss,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
);
    localparam int VW = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, WTHRU, EVICT, FILL, FWAIT} state_t;

    state_t state, state_n;
    logic op_wr, replay, any_hit, any_inv;
    logic [IDX_BITS-1:0] idx;
    logic [WAYS-2:0] plru_q [2**IDX_BITS];
    logic [WAYS-2:0] tree, tree_upd;
    logic [VW-1:0] hit_way, inv_way, lru_way, vic_n;
    logic [VW:0] dn, up, par;
    logic bit_n;

    assign tree    = plru_q[idx];
    assign any_hit = |lk_hit;
    assign vic_n   = any_inv ? inv_way : lru_way;

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        any_inv = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (lk_hit[i]) hit_way = VW'(i);
            if (!lk_val[i]) begin
                inv_way = VW'(i);
                any_inv = 1'b1;
            end
        end
    end

    // Descend from the root: node n has children 2n+1 (lower) and 2n+2 (upper).
    always_comb begin
        dn    = '0;
        bit_n = 1'b0;
        for (int l = 0; l < VW; l++) begin
            bit_n = 1'b0;
            for (int k = 0; k < WAYS - 1; k++)
                if (dn == (VW+1)'(k)) bit_n = tree[k];
            dn = {dn[VW-1:0], 1'b1} + {{VW{1'b0}}, bit_n};
        end
        lru_way = VW'(dn - (VW+1)'(WAYS - 1));
    end

    // Climb from the accessed leaf; a left (odd) child makes its parent point upper.
    always_comb begin
        tree_upd = tree;
        up       = {1'b0, hit_way} + (VW+1)'(WAYS - 1);
        par      = '0;
        for (int l = 0; l < VW; l++) begin
            par = (up - 1'b1) >> 1;
            for (int k = 0; k < WAYS - 1; k++)
                if (par == (VW+1)'(k)) tree_upd[k] = up[0];
            up = par;
        end
    end

    always_comb begin
        state_n   = state;
        pe_ready  = 1'b0;
        mm_read   = 1'b0;
        mm_write  = 1'b0;
        ary_write = '0;
        tag_write = '0;
        ary_fill  = 1'b0;
        val_set   = 1'b0;
        mod_set   = 1'b0;
        mod_clr   = 1'b0;
        rd_valid  = 1'b0;
        req_hit   = 1'b0;
        req_miss  = 1'b0;
        case (state)
            IDLE: begin
                pe_ready = 1'b1;
                state_n  = (pe_read | pe_write) ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                if (any_hit) begin
                    req_hit   = !replay;
                    rd_valid  = !op_wr;
                    mod_set   = op_wr;
                    ary_write = op_wr ? WAYS'(1) << hit_way : '0;
                    state_n   = IDLE;
                end else begin
                    req_miss = 1'b1;
                    state_n  = (op_wr && WRITE_ALLOC == 0) ? WTHRU : lk_mod[vic_n] ? EVICT : FILL;
                end
            end
            WTHRU: begin
                mm_write = 1'b1;
                state_n  = mm_busy ? WTHRU : IDLE;
            end
            EVICT: begin
                mm_write = 1'b1;
                state_n  = mm_busy ? EVICT : FILL;
            end
            FILL: begin
                mm_read = 1'b1;
                state_n = mm_busy ? FILL : FWAIT;
            end
            FWAIT: begin
                if (mm_readdata_valid) begin
                    ary_fill  = 1'b1;
                    ary_write = WAYS'(1) << victim_way;
                    tag_write = WAYS'(1) << victim_way;
                    val_set   = 1'b1;
                    mod_clr   = 1'b1;
                    state_n   = LOOKUP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_wr      <= 1'b0;
            idx        <= '0;
            replay     <= 1'b0;
            victim_way <= '0;
        end else begin
            state  <= state_n;
            replay <= state == FWAIT && mm_readdata_valid;
            if (state == IDLE && (pe_read | pe_write)) begin
                op_wr <= pe_write;
                idx   <= pe_index;
            end
            if (state == LOOKUP && !any_hit) victim_way <= vic_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**IDX_BITS; i++) plru_q[i] <= '0;
        end else if (state == LOOKUP && any_hit) begin
            plru_q[idx] <= tree_upd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (req_hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 32'd1;
            if (req_miss && !(&miss_cnt)) miss_cnt <= miss_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed checks of cache_miss_ctrl, write-allocate and write-through builds.
module tb_cache_miss_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic pe_read, pe_write, mm_busy, mm_readdata_valid;
    logic [12:0] pe_index;
    logic [3:0] lk_hit, lk_val, lk_mod;

    logic pe_ready, mm_read, mm_write, ary_fill, val_set, mod_set, mod_clr;
    logic rd_valid, req_hit, req_miss;
    logic [3:0] ary_write, tag_write;
    logic [1:0] victim_way;
    logic [31:0] hit_cnt, miss_cnt;

    logic pe_ready_0, mm_read_0, mm_write_0, ary_fill_0, val_set_0, mod_set_0, mod_clr_0;
    logic rd_valid_0, req_hit_0, req_miss_0;
    logic [3:0] ary_write_0, tag_write_0;
    logic [1:0] victim_way_0;
    logic [31:0] hit_cnt_0, miss_cnt_0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_miss_ctrl #(.WAYS(4), .IDX_BITS(13), .WRITE_ALLOC(1)) dut (
        .clk(clk), .reset(reset), .pe_read(pe_read), .pe_write(pe_write), .pe_index(pe_index),
        .pe_ready(pe_ready), .lk_hit(lk_hit), .lk_val(lk_val), .lk_mod(lk_mod),
        .mm_read(mm_read), .mm_write(mm_write), .mm_busy(mm_busy), .mm_readdata_valid(mm_readdata_valid),
        .ary_write(ary_write), .tag_write(tag_write), .ary_fill(ary_fill), .val_set(val_set),
        .mod_set(mod_set), .mod_clr(mod_clr), .victim_way(victim_way), .rd_valid(rd_valid),
        .req_hit(req_hit), .req_miss(req_miss), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_miss_ctrl #(.WAYS(4), .IDX_BITS(13), .WRITE_ALLOC(0)) dut0 (
        .clk(clk), .reset(reset), .pe_read(pe_read), .pe_write(pe_write), .pe_index(pe_index),
        .pe_ready(pe_ready_0), .lk_hit(lk_hit), .lk_val(lk_val), .lk_mod(lk_mod),
        .mm_read(mm_read_0), .mm_write(mm_write_0), .mm_busy(mm_busy), .mm_readdata_valid(mm_readdata_valid),
        .ary_write(ary_write_0), .tag_write(tag_write_0), .ary_fill(ary_fill_0), .val_set(val_set_0),
        .mod_set(mod_set_0), .mod_clr(mod_clr_0), .victim_way(victim_way_0), .rd_valid(rd_valid_0),
        .req_hit(req_hit_0), .req_miss(req_miss_0), .hit_cnt(hit_cnt_0), .miss_cnt(miss_cnt_0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clean_miss(input logic [12:0] idx);
        @(negedge clk); pe_read = 1'b1; pe_index = idx;
        @(negedge clk); pe_read = 1'b0; lk_hit = 4'b0000; lk_val = 4'b1110; lk_mod = 4'b0000;
        @(negedge clk); mm_busy = 1'b0;
        @(negedge clk); mm_readdata_valid = 1'b1;
        @(negedge clk); mm_readdata_valid = 1'b0; lk_hit = 4'b0001;
        @(negedge clk); lk_hit = 4'b0000;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {pe_read, pe_write, mm_busy, mm_readdata_valid} = '0;
        pe_index = '0; lk_hit = '0; lk_val = '0; lk_mod = '0;
        #2;
        check("rst_pe_ready", 32'(pe_ready), 1);
        check("rst_mm", 32'({mm_read, mm_write}), 0);
        check("rst_cnt", hit_cnt | miss_cnt, 0);

        // read hit on way 2, set 5
        @(negedge clk); reset = 1'b1; pe_read = 1'b1; pe_index = 13'd5;
        #1 check("idle_ready", 32'(pe_ready), 1);
        @(negedge clk); pe_read = 1'b0; lk_hit = 4'b0100; lk_val = 4'b1111;
        #1 check("hit_rd_valid", 32'(rd_valid), 1);
        check("hit_req_hit", 32'(req_hit), 1);
        check("hit_no_miss", 32'(req_miss), 0);
        @(negedge clk); lk_hit = 4'b0000;
        #1 check("hit_pulse_end", 32'({rd_valid, req_hit}), 0);
        check("hit_cnt1", hit_cnt, 1);
        check("plru_set5", 32'(dut.plru_q[5]), 32'h4);

        // clean read miss, way 2 invalid, fill with two busy cycles
        @(negedge clk); pe_read = 1'b1; pe_index = 13'd7;
        @(negedge clk); pe_read = 1'b0; lk_hit = 4'b0000; lk_val = 4'b1011; lk_mod = 4'b0000;
        #1 check("miss_req_miss", 32'(req_miss), 1);
        check("miss_no_rd", 32'(rd_valid), 0);
        @(negedge clk); mm_busy = 1'b1;
        #1 check("miss_victim", 32'(victim_way), 2);
        check("fill_rd1", 32'(mm_read), 1);
        @(negedge clk);
        #1 check("fill_rd2", 32'(mm_read), 1);
        @(negedge clk); mm_busy = 1'b0;
        #1 check("fill_rd3", 32'(mm_read), 1);
        @(negedge clk);
        #1 check("fwait_no_rd", 32'(mm_read), 0);
        check("fwait_idle_tag", 32'(tag_write), 0);
        @(negedge clk); mm_readdata_valid = 1'b1;
        #1 check("fill_tag_write", 32'(tag_write), 32'h4);
        check("fill_ary_write", 32'(ary_write), 32'h4);
        check("fill_status", 32'({ary_fill, val_set, mod_clr, mod_set}), 32'he);
        @(negedge clk); mm_readdata_valid = 1'b0; lk_hit = 4'b0100; lk_val = 4'b1111;
        #1 check("replay_rd_valid", 32'(rd_valid), 1);
        check("replay_no_hit", 32'(req_hit), 0);
        @(negedge clk); lk_hit = 4'b0000;
        #1 check("miss_cnt1", miss_cnt, 1);
        check("hit_cnt_replay", hit_cnt, 1);
        check("plru_set7", 32'(dut.plru_q[7]), 32'h4);

        // dirty write miss, all valid, pLRU zero -> victim 0; write-through build goes WTHRU
        @(negedge clk); pe_write = 1'b1; pe_index = 13'd9;
        @(negedge clk); pe_write = 1'b0; lk_val = 4'b1111; lk_mod = 4'b0001;
        #1 check("dmiss_req_miss", 32'(req_miss), 1);
        @(negedge clk); mm_busy = 1'b0;
        #1 check("evict_mm_write", 32'(mm_write), 1);
        check("evict_victim", 32'(victim_way), 0);
        check("evict_no_rd", 32'(mm_read), 0);
        check("wthru_mm_write", 32'(mm_write_0), 1);
        check("wthru_no_strobe", 32'({tag_write_0, ary_write_0}), 0);
        @(negedge clk);
        #1 check("evict_fill", 32'({mm_read, mm_write}), 32'h2);
        check("wthru_idle", 32'({pe_ready_0, mm_write_0}), 32'h2);
        check("wthru_no_strobe2", 32'({tag_write_0, ary_write_0}), 0);
        @(negedge clk); mm_readdata_valid = 1'b1;
        #1 check("dfill_tag", 32'(tag_write), 32'h1);
        check("idle_rdv_ignored", 32'({tag_write_0, ary_write_0, val_set_0}), 0);
        @(negedge clk); mm_readdata_valid = 1'b0; lk_hit = 4'b0001; lk_mod = 4'b0000;
        #1 check("dreplay_ary_write", 32'(ary_write), 32'h1);
        check("dreplay_mod_set", 32'({mod_set, req_hit, rd_valid}), 32'h4);
        @(negedge clk); lk_hit = 4'b0000;
        #1 check("miss_cnt2", miss_cnt, 2);
        check("plru_set9", 32'(dut.plru_q[9]), 32'h3);

        // write hit with both strobes high counts as a write
        @(negedge clk); pe_read = 1'b1; pe_write = 1'b1; pe_index = 13'd11;
        @(negedge clk); pe_read = 1'b0; pe_write = 1'b0; lk_hit = 4'b0010;
        #1 check("whit_ary_write", 32'(ary_write), 32'h2);
        check("whit_flags", 32'({mod_set, req_hit, rd_valid}), 32'h6);
        @(negedge clk); lk_hit = 4'b0000;
        #1 check("hit_cnt2", hit_cnt, 2);

        // reset while the fill data is arriving
        @(negedge clk); pe_read = 1'b1; pe_index = 13'd13;
        @(negedge clk); pe_read = 1'b0; lk_val = 4'b0111;
        @(negedge clk); mm_busy = 1'b0;
        @(negedge clk); mm_readdata_valid = 1'b1;
        #1 check("pre_rst_tag", 32'(tag_write), 32'h8);
        reset = 1'b0;
        #1 check("rst_strobes", 32'({tag_write, ary_write, val_set, mod_clr, ary_fill}), 0);
        check("rst_ready_async", 32'(pe_ready), 1);
        check("rst_cnt_async", hit_cnt | miss_cnt, 0);
        check("rst_plru", 32'(dut.plru_q[7]), 0);
        @(negedge clk); reset = 1'b1; pe_read = 1'b1; pe_index = 13'd2;
        #1 check("post_rst_no_strobe", 32'({tag_write, ary_write, val_set}), 0);
        @(negedge clk); pe_read = 1'b0; mm_readdata_valid = 1'b0; lk_hit = 4'b1000; lk_val = 4'b1111;
        #1 check("post_rst_accept", 32'({rd_valid, req_hit}), 32'h3);
        @(negedge clk); lk_hit = 4'b0000;

        // miss counter saturation
        force dut.miss_cnt = 32'hFFFFFFFE;
        #1 release dut.miss_cnt;
        #1 check("preload", miss_cnt, 32'hFFFFFFFE);
        clean_miss(13'd20);
        check("sat_miss1", miss_cnt, 32'hFFFFFFFF);
        clean_miss(13'd21);
        clean_miss(13'd22);
        check("sat_miss3", miss_cnt, 32'hFFFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
